// File: rtl/spi_cfg_engine.sv
// SPI configuration master: walks an external register table and shifts each entry
// out as one chip-select-framed word (SCLK idles high, MSB first), capturing MISO for readback.
module spi_cfg_engine #(
  parameter int FRAME_W = 14,
  parameter int NUM_REG = 32,
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4,
  parameter bit CS_ACT  = 1'b1,
  localparam int AW     = (NUM_REG > 1) ? $clog2(NUM_REG) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [AW:0]        cfg_num,
  output logic [AW-1:0]      tbl_addr,
  input  logic [FRAME_W-1:0] tbl_data,
  output logic               busy,
  output logic               done,
  output logic [FRAME_W-1:0] rd_data,
  output logic               rd_valid,
  output logic               cs_spi,
  output logic               clk_spi,
  output logic               mosi,
  input  logic               miso
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(FRAME_W + 1);
  localparam int GW = $clog2(CS_GAP + 1);
  localparam int IW = AW + 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
  localparam logic [IW-1:0] NUM_MAX  = IW'(NUM_REG);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LOAD, S_LEAD, S_SHIFT_LO, S_SHIFT_HI, S_TRAIL, S_GAP, S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0]      div_cnt;
  logic [BW-1:0]      bit_cnt;
  logic [GW-1:0]      gap_cnt;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      n_ent;
  logic [IW-1:0]      idx_inc;
  logic [IW-1:0]      cfg_eff;
  logic               div_last;
  logic               bit_last;
  logic               gap_last;
  logic               more;
  logic               timed;
  logic [FRAME_W-1:0] tx_sh;
  logic [FRAME_W-1:0] rx_sh;

  logic               cs_d;
  logic               sclk_d;
  logic               mosi_d;
  logic               busy_d;
  logic               done_d;
  logic               rdv_d;
  logic [FRAME_W-1:0] rd_data_d;
  logic [AW-1:0]      tbl_addr_d;

  assign div_last = (div_cnt == DIV_LAST);
  assign bit_last = (bit_cnt == BIT_LAST);
  assign gap_last = (gap_cnt == GAP_LAST);
  assign idx_inc  = idx + IW'(1);
  // idx carries one extra bit so idx+1 == NUM_REG compares correctly without wrapping
  assign more     = (idx_inc < n_ent);
  assign cfg_eff  = ((cfg_num == '0) || (cfg_num > NUM_MAX)) ? NUM_MAX : cfg_num;
  assign timed    = (state == S_LEAD) || (state == S_SHIFT_LO) ||
                    (state == S_SHIFT_HI) || (state == S_TRAIL);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_FETCH;
      S_FETCH:    state_nxt = S_LOAD;
      S_LOAD:     state_nxt = S_LEAD;
      S_LEAD:     if (div_last) state_nxt = S_SHIFT_LO;
      S_SHIFT_LO: if (div_last) state_nxt = S_SHIFT_HI;
      S_SHIFT_HI: if (div_last) state_nxt = bit_last ? S_TRAIL : S_SHIFT_LO;
      S_TRAIL:    if (div_last) state_nxt = S_GAP;
      S_GAP:      if (gap_last) state_nxt = more ? S_FETCH : S_FIN;
      S_FIN:      state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Next value of every registered output, derived from the current state and its exit condition
  always_comb begin
    cs_d       = cs_spi;
    sclk_d     = clk_spi;
    mosi_d     = mosi;
    busy_d     = busy;
    done_d     = 1'b0;
    rdv_d      = 1'b0;
    rd_data_d  = rd_data;
    tbl_addr_d = tbl_addr;
    case (state)
      S_IDLE: begin
        if (start) begin
          busy_d     = 1'b1;
          tbl_addr_d = '0;
        end
      end
      S_LOAD: begin
        cs_d   = CS_ACT;
        mosi_d = tbl_data[FRAME_W-1];
      end
      S_LEAD: begin
        if (div_last) sclk_d = 1'b0;
      end
      S_SHIFT_LO: begin
        if (div_last) sclk_d = 1'b1;
      end
      S_SHIFT_HI: begin
        if (div_last && !bit_last) begin
          sclk_d = 1'b0;
          mosi_d = tx_sh[FRAME_W-2];
        end
      end
      S_TRAIL: begin
        if (div_last) begin
          cs_d      = ~CS_ACT;
          mosi_d    = 1'b0;
          rdv_d     = 1'b1;
          rd_data_d = rx_sh;
        end
      end
      S_GAP: begin
        if (gap_last && more) tbl_addr_d = idx_inc[AW-1:0];
      end
      S_FIN: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_spi   <= ~CS_ACT;
      clk_spi  <= 1'b1;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      tbl_addr <= '0;
    end else begin
      cs_spi   <= cs_d;
      clk_spi  <= sclk_d;
      mosi     <= mosi_d;
      busy     <= busy_d;
      done     <= done_d;
      rd_valid <= rdv_d;
      rd_data  <= rd_data_d;
      tbl_addr <= tbl_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      idx     <= '0;
      n_ent   <= '0;
    end else begin
      if (timed && !div_last) div_cnt <= div_cnt + DW'(1);
      else                    div_cnt <= '0;

      if ((state == S_GAP) && !gap_last) gap_cnt <= gap_cnt + GW'(1);
      else                               gap_cnt <= '0;

      if (state == S_LOAD)                          bit_cnt <= '0;
      else if ((state == S_SHIFT_HI) && div_last)   bit_cnt <= bit_cnt + BW'(1);

      if ((state == S_IDLE) && start) begin
        idx   <= '0;
        n_ent <= cfg_eff;
      end else if ((state == S_GAP) && gap_last) begin
        idx   <= idx_inc;
      end
    end
  end

  // Frame shift registers hold pure data and need no reset: LOAD overwrites tx, and rx is fully refilled each frame
  always_ff @(posedge clk) begin
    if (state == S_LOAD)
      tx_sh <= tbl_data;
    else if ((state == S_SHIFT_HI) && div_last && !bit_last)
      tx_sh <= tx_sh << 1;

    if ((state == S_SHIFT_LO) && div_last)
      rx_sh <= {rx_sh[FRAME_W-2:0], miso};
  end

endmodule

// File: tb/tb_spi_cfg_engine.sv
// Directed bench for spi_cfg_engine: a default-parameter instance with MISO looped to MOSI,
// and a 24-bit active-low instance whose slave shifts a fixed pattern out on MISO.
module tb_spi_cfg_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic mon_clr = 1'b0;

  // ---------------- instance A: defaults ----------------
  logic        start_a = 1'b0;
  logic [5:0]  cfg_num_a = '0;
  logic [4:0]  tbl_addr_a;
  logic [13:0] tbl_data_a = '0;
  logic        busy_a, done_a, rd_valid_a, cs_a, sclk_a, mosi_a, miso_a;
  logic [13:0] rd_data_a;
  assign miso_a = mosi_a;

  spi_cfg_engine u_a (
    .clk(clk), .rst(rst), .start(start_a), .cfg_num(cfg_num_a),
    .tbl_addr(tbl_addr_a), .tbl_data(tbl_data_a), .busy(busy_a), .done(done_a),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .cs_spi(cs_a), .clk_spi(sclk_a),
    .mosi(mosi_a), .miso(miso_a)
  );

  always @(posedge clk) tbl_data_a <= 14'h2A00 + {9'b0, tbl_addr_a};

  // ---------------- instance B: 24-bit, CLK_DIV=1, active-low CS ----------------
  logic        start_b = 1'b0;
  logic [2:0]  cfg_num_b = '0;
  logic [1:0]  tbl_addr_b;
  logic [23:0] tbl_data_b = '0;
  logic        busy_b, done_b, rd_valid_b, cs_b, sclk_b, mosi_b, miso_b;
  logic [23:0] rd_data_b;
  logic [23:0] pat_b = 24'hA5C3F0;
  int          falls_b = 0;

  always_comb begin
    miso_b = pat_b[23];
    if (falls_b >= 1 && falls_b <= 24) miso_b = pat_b[24 - falls_b];
  end

  spi_cfg_engine #(.FRAME_W(24), .NUM_REG(4), .CLK_DIV(1), .CS_GAP(1), .CS_ACT(1'b0)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .cfg_num(cfg_num_b),
    .tbl_addr(tbl_addr_b), .tbl_data(tbl_data_b), .busy(busy_b), .done(done_b),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .cs_spi(cs_b), .clk_spi(sclk_b),
    .mosi(mosi_b), .miso(miso_b)
  );

  always @(posedge clk) tbl_data_b <= 24'h5A0000 + {22'b0, tbl_addr_b};

  // ---------------- monitors (sample on falling clk) ----------------
  int nf_a = 0, nrdv_a = 0, ndone_a = 0, done_cyc_a = -1, len_a = 0, bits_a = 0;
  logic in_a = 1'b0, psclk_a = 1'b1;
  logic [13:0] sh_a = '0;
  logic [13:0] fw_a [40];
  logic [13:0] rdd_a [40];
  logic        frdv_a [40];
  int flen_a [40], fbits_a [40], fst_a [40], faddr_a [40], ffall_a [40];

  int nf_b = 0, nrdv_b = 0, ndone_b = 0, done_cyc_b = -1, len_b = 0;
  logic in_b = 1'b0, psclk_b = 1'b1;
  logic [23:0] sh_b = '0;
  logic [23:0] fw_b [8];
  logic [23:0] rdd_b [8];
  int flen_b [8], fst_b [8];

  always @(negedge clk) begin
    if (mon_clr) begin
      nf_a = 0; nrdv_a = 0; ndone_a = 0; done_cyc_a = -1;
      nf_b = 0; nrdv_b = 0; ndone_b = 0; done_cyc_b = -1;
    end
    if (rst) begin
      in_a = 1'b0; in_b = 1'b0; falls_b = 0;
    end else begin
      if (cs_a) begin
        if (!in_a) begin
          in_a = 1'b1; len_a = 0; bits_a = 0;
          if (nf_a < 40) begin fst_a[nf_a] = cyc; faddr_a[nf_a] = int'(tbl_addr_a); ffall_a[nf_a] = -1; end
        end
        len_a++;
        if (!psclk_a && sclk_a) begin sh_a = {sh_a[12:0], mosi_a}; bits_a++; end
        if (psclk_a && !sclk_a && bits_a == 0 && nf_a < 40) ffall_a[nf_a] = cyc;
      end else if (in_a) begin
        in_a = 1'b0;
        if (nf_a < 40) begin
          fw_a[nf_a] = sh_a; flen_a[nf_a] = len_a; fbits_a[nf_a] = bits_a; frdv_a[nf_a] = rd_valid_a;
          nf_a++;
        end
      end
      if (rd_valid_a) begin if (nrdv_a < 40) rdd_a[nrdv_a] = rd_data_a; nrdv_a++; end
      if (done_a) begin ndone_a++; done_cyc_a = cyc; end

      if (!cs_b) begin
        if (!in_b) begin
          in_b = 1'b1; len_b = 0;
          if (nf_b < 8) fst_b[nf_b] = cyc;
        end
        len_b++;
        if (!psclk_b && sclk_b) sh_b = {sh_b[22:0], mosi_b};
        if (psclk_b && !sclk_b) falls_b++;
      end else begin
        falls_b = 0;
        if (in_b) begin
          in_b = 1'b0;
          if (nf_b < 8) begin fw_b[nf_b] = sh_b; flen_b[nf_b] = len_b; nf_b++; end
        end
      end
      if (rd_valid_b) begin if (nrdv_b < 8) rdd_b[nrdv_b] = rd_data_b; nrdv_b++; end
      if (done_b) begin ndone_b++; done_cyc_b = cyc; end
    end
    psclk_a = sclk_a;
    psclk_b = sclk_b;
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1; tick(1); mon_clr = 1'b0;
  endtask

  task automatic start_a_pass(input logic [5:0] num, output int t0);
    cfg_num_a = num; start_a = 1'b1; t0 = cyc; tick(1); start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    int n = 0;
    while (ndone_a == 0 && n < budget) begin tick(1); n++; end
    checks++;
    if (ndone_a == 0) begin errors++; $display("FAIL done_a_timeout: no done after %0d cycles", budget); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (cs_a !== 1'b0)       begin errors++; $display("FAIL rst_cs_a: got %b want 0", cs_a); end
    checks++; if (sclk_a !== 1'b1)     begin errors++; $display("FAIL rst_sclk_a: got %b want 1", sclk_a); end
    checks++; if (mosi_a !== 1'b0)     begin errors++; $display("FAIL rst_mosi_a: got %b want 0", mosi_a); end
    checks++; if (busy_a !== 1'b0)     begin errors++; $display("FAIL rst_busy_a: got %b want 0", busy_a); end
    checks++; if (done_a !== 1'b0)     begin errors++; $display("FAIL rst_done_a: got %b want 0", done_a); end
    checks++; if (rd_valid_a !== 1'b0) begin errors++; $display("FAIL rst_rdv_a: got %b want 0", rd_valid_a); end
    checks++; if (rd_data_a !== 14'h0) begin errors++; $display("FAIL rst_rdd_a: got %h want 0", rd_data_a); end
    checks++; if (tbl_addr_a !== 5'd0) begin errors++; $display("FAIL rst_addr_a: got %0d want 0", tbl_addr_a); end
    checks++; if (cs_b !== 1'b1)       begin errors++; $display("FAIL rst_cs_b: got %b want 1", cs_b); end
    checks++; if (sclk_b !== 1'b1)     begin errors++; $display("FAIL rst_sclk_b: got %b want 1", sclk_b); end
  endtask

  task automatic test_basic();
    int t0;
    logic [13:0] w;
    clear_mon();
    start_a_pass(6'd3, t0);
    checks++; if (busy_a !== 1'b1)     begin errors++; $display("FAIL basic_busy_t1: got %b want 1", busy_a); end
    checks++; if (tbl_addr_a !== 5'd0) begin errors++; $display("FAIL basic_addr_t1: got %0d want 0", tbl_addr_a); end
    wait_done_a(400);
    tick(3);
    checks++; if (nf_a != 3) begin errors++; $display("FAIL basic_frames: got %0d want 3", nf_a); end
    for (int k = 0; k < 3; k++) begin
      w = 14'h2A00 + 14'(k);
      checks++; if (fw_a[k] !== w)    begin errors++; $display("FAIL basic_slave_word%0d: got %h want %h", k, fw_a[k], w); end
      checks++; if (rdd_a[k] !== w)   begin errors++; $display("FAIL basic_rd_data%0d: got %h want %h", k, rdd_a[k], w); end
      checks++; if (flen_a[k] != 60)  begin errors++; $display("FAIL basic_cs_len%0d: got %0d want 60", k, flen_a[k]); end
      checks++; if (fbits_a[k] != 14) begin errors++; $display("FAIL basic_bits%0d: got %0d want 14", k, fbits_a[k]); end
      checks++; if (frdv_a[k] !== 1'b1) begin errors++; $display("FAIL basic_rdv_at_deassert%0d: got %b want 1", k, frdv_a[k]); end
      checks++; if (fst_a[k] != t0 + 3 + 66*k) begin errors++; $display("FAIL basic_cs_start%0d: got %0d want %0d", k, fst_a[k], t0 + 3 + 66*k); end
    end
    checks++; if (ffall_a[0] != t0 + 5) begin errors++; $display("FAIL basic_first_fall: got %0d want %0d", ffall_a[0], t0 + 5); end
    checks++; if (ndone_a != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", ndone_a); end
    checks++; if (done_cyc_a != t0 + 200) begin errors++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc_a, t0 + 200); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy_a); end
  endtask

  task automatic test_start_ignored();
    int t0;
    int n = 0;
    clear_mon();
    start_a_pass(6'd3, t0);
    while (!(nf_a >= 1 && in_a) && n < 300) begin tick(1); n++; end
    tick(10);
    start_a = 1'b1; tick(1); start_a = 1'b0;
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b want 1", busy_a); end
    wait_done_a(400);
    tick(150);
    checks++; if (nf_a != 3)    begin errors++; $display("FAIL ign_frames: got %0d want 3", nf_a); end
    checks++; if (ndone_a != 1) begin errors++; $display("FAIL ign_done_count: got %0d want 1", ndone_a); end
    checks++; if (done_cyc_a != t0 + 200) begin errors++; $display("FAIL ign_done_cycle: got %0d want %0d", done_cyc_a, t0 + 200); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL ign_busy_after: got %b want 0", busy_a); end
  endtask

  task automatic test_full_table();
    int t0;
    int bad_addr;
    int bad_word;
    for (int pass = 0; pass < 2; pass++) begin
      clear_mon();
      start_a_pass(6'd0, t0);
      wait_done_a(2300);
      tick(3);
      checks++; if (nf_a != 32) begin errors++; $display("FAIL full%0d_frames: got %0d want 32", pass, nf_a); end
      bad_addr = 0; bad_word = 0;
      for (int k = 0; k < 32; k++) begin
        if (faddr_a[k] != k) bad_addr++;
        if (fw_a[k] !== 14'h2A00 + 14'(k)) bad_word++;
      end
      checks++; if (bad_addr != 0) begin errors++; $display("FAIL full%0d_addr_seq: got %0d wrong want 0", pass, bad_addr); end
      checks++; if (bad_word != 0) begin errors++; $display("FAIL full%0d_words: got %0d wrong want 0", pass, bad_word); end
      checks++; if (faddr_a[31] != 31) begin errors++; $display("FAIL full%0d_last_addr: got %0d want 31", pass, faddr_a[31]); end
      checks++; if (fst_a[0] != t0 + 3) begin errors++; $display("FAIL full%0d_first_cs: got %0d want %0d", pass, fst_a[0], t0 + 3); end
      checks++; if (ndone_a != 1) begin errors++; $display("FAIL full%0d_done_count: got %0d want 1", pass, ndone_a); end
      checks++; if (done_cyc_a != t0 + 3 + 31*66 + 60 + 5) begin
        errors++; $display("FAIL full%0d_done_cycle: got %0d want %0d", pass, done_cyc_a, t0 + 3 + 31*66 + 65);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int t0;
    int n = 0;
    int rises = 0;
    logic p = 1'b1;
    clear_mon();
    start_a_pass(6'd3, t0);
    while (rises < 7 && n < 500) begin
      tick(1); n++;
      if (cs_a && sclk_a && !p) rises++;
      p = sclk_a;
    end
    checks++; if (rises != 7) begin errors++; $display("FAIL mid_rise_wait: got %0d want 7", rises); end
    rst = 1'b1;
    tick(1);
    checks++; if (cs_a !== 1'b0)   begin errors++; $display("FAIL mid_cs: got %b want 0", cs_a); end
    checks++; if (sclk_a !== 1'b1) begin errors++; $display("FAIL mid_sclk: got %b want 1", sclk_a); end
    checks++; if (mosi_a !== 1'b0) begin errors++; $display("FAIL mid_mosi: got %b want 0", mosi_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy_a); end
    rst = 1'b0;
    tick(150);
    checks++; if (nrdv_a != 0)  begin errors++; $display("FAIL mid_no_rdv: got %0d want 0", nrdv_a); end
    checks++; if (ndone_a != 0) begin errors++; $display("FAIL mid_no_done: got %0d want 0", ndone_a); end
    checks++; if (nf_a != 0)    begin errors++; $display("FAIL mid_no_frame: got %0d want 0", nf_a); end
    clear_mon();
    start_a_pass(6'd1, t0);
    wait_done_a(200);
    tick(3);
    checks++; if (nf_a != 1) begin errors++; $display("FAIL mid_restart_frames: got %0d want 1", nf_a); end
    checks++; if (fw_a[0] !== 14'h2A00)  begin errors++; $display("FAIL mid_restart_word: got %h want 2a00", fw_a[0]); end
    checks++; if (faddr_a[0] != 0)       begin errors++; $display("FAIL mid_restart_addr: got %0d want 0", faddr_a[0]); end
    checks++; if (rdd_a[0] !== 14'h2A00) begin errors++; $display("FAIL mid_restart_rdd: got %h want 2a00", rdd_a[0]); end
    checks++; if (done_cyc_a != t0 + 3 + 60 + 5) begin errors++; $display("FAIL mid_restart_done: got %0d want %0d", done_cyc_a, t0 + 68); end
  endtask

  task automatic test_wide();
    int t0;
    int n = 0;
    clear_mon();
    cfg_num_b = 3'd2; start_b = 1'b1; t0 = cyc; tick(1); start_b = 1'b0;
    checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL wide_busy_t1: got %b want 1", busy_b); end
    while (ndone_b == 0 && n < 300) begin tick(1); n++; end
    checks++; if (ndone_b == 0) begin errors++; $display("FAIL wide_done_timeout: no done after %0d cycles", n); end
    tick(3);
    checks++; if (nrdv_b != 2) begin errors++; $display("FAIL wide_rdv_count: got %0d want 2", nrdv_b); end
    checks++; if (rdd_b[0] !== 24'hA5C3F0) begin errors++; $display("FAIL wide_rdd0: got %h want a5c3f0", rdd_b[0]); end
    checks++; if (rdd_b[1] !== 24'hA5C3F0) begin errors++; $display("FAIL wide_rdd1: got %h want a5c3f0", rdd_b[1]); end
    checks++; if (flen_b[0] != 50) begin errors++; $display("FAIL wide_cs_len0: got %0d want 50", flen_b[0]); end
    checks++; if (flen_b[1] != 50) begin errors++; $display("FAIL wide_cs_len1: got %0d want 50", flen_b[1]); end
    checks++; if (fst_b[0] != t0 + 3) begin errors++; $display("FAIL wide_cs_start: got %0d want %0d", fst_b[0], t0 + 3); end
    checks++; if (fst_b[1] - fst_b[0] != 53) begin errors++; $display("FAIL wide_period: got %0d want 53", fst_b[1] - fst_b[0]); end
    checks++; if (fw_b[0] !== 24'h5A0000) begin errors++; $display("FAIL wide_mosi0: got %h want 5a0000", fw_b[0]); end
    checks++; if (fw_b[1] !== 24'h5A0001) begin errors++; $display("FAIL wide_mosi1: got %h want 5a0001", fw_b[1]); end
    checks++; if (done_cyc_b != t0 + 3 + 53 + 50 + 2) begin errors++; $display("FAIL wide_done_cycle: got %0d want %0d", done_cyc_b, t0 + 108); end
    checks++; if (cs_b !== 1'b1) begin errors++; $display("FAIL wide_cs_idle: got %b want 1", cs_b); end
  endtask

  initial begin
    rst = 1'b1;
    tick(4);
    test_reset();
    rst = 1'b0;
    tick(2);
    test_basic();
    tick(5);
    test_start_ignored();
    tick(5);
    test_full_table();
    tick(5);
    test_reset_midframe();
    tick(5);
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
